snoop_ctrl: RTL and testbench
=============================

# snoop_ctrl

Bus-side snoop controller that sits directly upstream of the cache directory. It captures system-bus transactions into a small request queue and issues one lookup at a time to the directory over its snoop/ADDR/STATUS interface. It then applies the MESI coherence action for each lookup: writeback, invalidate, downgrade, or shared response. Every state change it decides is written back to the directory through an update port.

## Interface
Parameters:
- QDEPTH, 4, pending-request queue depth (power of two, ≥2)
- LOOKUP_LAT, 1, cycles from snoop strobe to valid STATUS (1–4)

Ports:
- SCLK  in  1  clock, all logic on rising edge
- SRST  in  1  reset, asynchronous, active-low
- BUS_VALID  in  1  bus transaction present
- BUS_ADDR  in  24  transaction address: [23:8] tag, [7:0] index
- BUS_RW  in  1  1 = write/RFO by another agent, 0 = read
- BUS_READY  out  1  queue can accept (not full)
- snoop  out  1  one-cycle directory lookup strobe
- ADDR  out  24  lookup address, valid while snoop = 1
- STATUS  in  2  directory state: 00 I, 01 S, 10 E, 11 M
- UPD_VALID  out  1  directory state-write strobe
- UPD_INDEX  out  8  line index to update
- UPD_STATE  out  2  new state
- PINV  out  1  invalidate pulse
- SHARED  out  1  bus shared-response pulse
- WB_REQ  out  1  writeback request (level)
- WB_ADDR  out  24  writeback line address
- WB_ACK  in  1  writeback accepted
- DONE  out  1  one-cycle pulse per completed snoop

## Operation
- Queue: FIFO of {addr[23:0], rw}. Push on an edge with BUS_VALID & BUS_READY. BUS_READY = !full.
- Push and pop on the same edge are legal, including when the queue is full. BUS_READY still reads 0 while full.
- States:
  - IDLE: when the queue is non-empty, pop into the current register and go to LOOKUP.
  - LOOKUP: snoop = 1, ADDR = current addr. Go to WAIT.
  - WAIT: hold for LOOKUP_LAT cycles. Sample STATUS on the last edge, then go to WB if STATUS = 11, otherwise go to RESP.
  - WB: WB_REQ = 1, WB_ADDR = current addr, held until the edge with WB_ACK = 1. Then go to RESP.
  - RESP: one cycle, outputs per the action rules below. Then go to IDLE.
- Action rules (current rw, sampled STATUS):
  - I: no UPD, no PINV, no SHARED.
  - S, read: SHARED = 1, no update.
  - E or M, read: SHARED = 1, UPD_STATE = 01.
  - S, E or M, write: PINV = 1, UPD_STATE = 00.
- UPD_VALID = 1 exactly when an update is listed above. UPD_INDEX = addr[7:0].
- DONE = 1 in every RESP cycle.
- One snoop in flight at a time. Entries are served in strict arrival order.
- STATUS is ignored outside the sampling edge.

## Timing
- Reset values: BUS_READY 1, snoop 0, ADDR 0, UPD_VALID 0, UPD_INDEX 0, UPD_STATE 0, PINV 0, SHARED 0, WB_REQ 0, WB_ADDR 0, DONE 0. State IDLE, queue empty.
- All outputs are registered or decoded from registered state. No combinational input-to-output path, except that BUS_READY depends only on the occupancy count.
- Latency with LOOKUP_LAT = 1, non-M line, empty queue:
  - accept edge k;
  - snoop high in cycle k+1..k+2;
  - STATUS sampled at edge k+3;
  - DONE high in cycle k+3..k+4.
- Each extra LOOKUP_LAT cycle adds one cycle.
- An M line adds the cycles spent in WB: at least 1, ending on the WB_ACK edge.
- WB_ACK high on the first WB cycle leaves WB after that single cycle.
- WB_ACK outside the WB state is ignored.
- Back-to-back throughput: one snoop per (3 + LOOKUP_LAT) cycles. IDLE lasts one cycle between snoops.
- Pointer wrap: read/write pointers carry log2(QDEPTH) bits plus one wrap bit. Full = same index with opposite wrap bit.
- SRST asserted mid-operation:
  - queue flushed, FSM to IDLE;
  - a pending WB_REQ is dropped immediately (asynchronously);
  - no DONE and no UPD for the aborted snoop.

## Configuration
- SNOOP_STATS_EN defined: adds outputs HIT_CNT[15:0] and INV_CNT[15:0].
  - HIT_CNT increments in RESP when the sampled STATUS ≠ 00.
  - INV_CNT increments in RESP when PINV = 1.
  - Both counters saturate at 16'hFFFF and reset to 0.
- SNOOP_STATS_EN undefined: both ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Read to an E line: BUS_ADDR 24'h12_3445, RW = 0, STATUS = 10. Expect snoop in cycle k+1, then in cycle k+3 DONE = 1, SHARED = 1, UPD_VALID = 1, UPD_INDEX = 8'h45, UPD_STATE = 01, PINV = 0.
- Write to an M line: RW = 1, STATUS = 11, WB_ACK delayed 3 cycles. Expect WB_REQ held 3 cycles with WB_ADDR = BUS_ADDR, then RESP with PINV = 1 and UPD_STATE = 00.
- Miss: STATUS = 00 with both RW values. Expect DONE only, with UPD_VALID, PINV and SHARED all 0.
- Queue full: push 5 requests back-to-back, QDEPTH = 4, FSM stalled in WB.
  - BUS_READY drops after the 4th push; the 5th request waits.
  - Snoops complete in address order.
  - A simultaneous push and pop while full is accepted.
- Reset mid-WB: assert SRST while WB_REQ = 1. Expect WB_REQ to fall with no clock edge, all outputs at reset values, queue empty and BUS_READY = 1.
- With SNOOP_STATS_EN: 3 hits (one of them a write) and 1 miss. Expect HIT_CNT = 3 and INV_CNT = 1.

Source files
------------

// File: rtl/snoop_ctrl_if.sv
// snoop_ctrl_if: system-bus request, directory lookup/update and writeback
// signals of the snoop controller. Defining SNOOP_STATS_EN adds HIT_CNT/INV_CNT.
interface snoop_ctrl_if;
   logic        BUS_VALID;
   logic [23:0] BUS_ADDR;
   logic        BUS_RW;
   logic        BUS_READY;
   logic        snoop;
   logic [23:0] ADDR;
   logic [1:0]  STATUS;
   logic        UPD_VALID;
   logic [7:0]  UPD_INDEX;
   logic [1:0]  UPD_STATE;
   logic        PINV;
   logic        SHARED;
   logic        WB_REQ;
   logic [23:0] WB_ADDR;
   logic        WB_ACK;
   logic        DONE;
`ifdef SNOOP_STATS_EN
   logic [15:0] HIT_CNT;
   logic [15:0] INV_CNT;
`endif

   // Controller side
   modport slave (
      input  BUS_VALID, BUS_ADDR, BUS_RW, STATUS, WB_ACK,
      output BUS_READY, snoop, ADDR, UPD_VALID, UPD_INDEX, UPD_STATE,
             PINV, SHARED, WB_REQ, WB_ADDR, DONE
`ifdef SNOOP_STATS_EN
      , HIT_CNT, INV_CNT
`endif
   );

   // Bus / directory / memory side
   modport master (
      output BUS_VALID, BUS_ADDR, BUS_RW, STATUS, WB_ACK,
      input  BUS_READY, snoop, ADDR, UPD_VALID, UPD_INDEX, UPD_STATE,
             PINV, SHARED, WB_REQ, WB_ADDR, DONE
`ifdef SNOOP_STATS_EN
      , HIT_CNT, INV_CNT
`endif
   );
endinterface

// File: rtl/snoop_ctrl.sv
// snoop_ctrl: queues bus transactions, looks each one up in the cache
// directory, and applies the MESI snoop action (writeback, invalidate,
// downgrade, shared response). Optional macro SNOOP_STATS_EN adds
// saturating hit / invalidate counters.
module snoop_ctrl #(
   parameter int unsigned QDEPTH     = 4,
   parameter int unsigned LOOKUP_LAT = 1
) (
   input  logic        SCLK,
   input  logic        SRST,
   snoop_ctrl_if.slave bus
);
   localparam int unsigned PTR_W  = $clog2(QDEPTH);
   localparam int unsigned ADDR_W = 24;
   localparam int unsigned LAT_W  = 2;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOOKUP = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_WB     = 3'd3;
   localparam logic [2:0] S_RESP   = 3'd4;

   localparam logic [1:0] ST_I = 2'b00;
   localparam logic [1:0] ST_S = 2'b01;
   localparam logic [1:0] ST_M = 2'b11;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              rw;
   } req_t;

   req_t             mem_q [QDEPTH];
   req_t             mem_d [QDEPTH];
   logic [PTR_W:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic             ready_q, ready_d;
   logic             empty_c, full_c, push_c, pop_c;

   logic [2:0]       state_q, state_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   req_t             cur_q, cur_d;
   logic [1:0]       stat_q, stat_d;
   logic             snoop_q, snoop_d;
   logic             wb_req_q, wb_req_d;
   logic             done_q, done_d;
   logic             shared_q, shared_d;
   logic             pinv_q, pinv_d;
   logic             upd_valid_q, upd_valid_d;
   logic [7:0]       upd_index_q, upd_index_d;
   logic [1:0]       upd_state_q, upd_state_d;

   // Queue status; a pop frees the slot so a push is taken even when full
   always_comb begin
      empty_c = (wptr_q == rptr_q);
      full_c  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
      pop_c   = (state_q == S_IDLE) && !empty_c;
      push_c  = bus.BUS_VALID && (!full_c || pop_c);
   end

   // Queue storage and pointer update; ready reflects next occupancy
   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push_c) begin
         mem_d[wptr_q[PTR_W-1:0]] = '{addr: bus.BUS_ADDR, rw: bus.BUS_RW};
         wptr_d = wptr_q + (PTR_W+1)'(1);
      end
      if (pop_c) begin
         rptr_d = rptr_q + (PTR_W+1)'(1);
      end
      ready_d = !((wptr_d[PTR_W] != rptr_d[PTR_W]) &&
                  (wptr_d[PTR_W-1:0] == rptr_d[PTR_W-1:0]));
   end

   // Queue registers
   always_ff @(posedge SCLK or negedge SRST) begin
      if (!SRST) begin
         for (int unsigned i = 0; i < QDEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wptr_q  <= '0;
         rptr_q  <= '0;
         ready_q <= 1'b1;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         ready_q <= ready_d;
      end
   end

   // Snoop FSM next state and next registered outputs
   always_comb begin
      state_d     = state_q;
      lat_d       = lat_q;
      cur_d       = cur_q;
      stat_d      = stat_q;
      snoop_d     = 1'b0;
      wb_req_d    = 1'b0;
      done_d      = 1'b0;
      shared_d    = 1'b0;
      pinv_d      = 1'b0;
      upd_valid_d = 1'b0;
      upd_index_d = 8'h00;
      upd_state_d = ST_I;

      case (state_q)
         S_IDLE: begin
            if (pop_c) begin
               cur_d   = mem_q[rptr_q[PTR_W-1:0]];
               snoop_d = 1'b1;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            lat_d   = LAT_W'(LOOKUP_LAT - 1);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (lat_q == '0) begin
               stat_d = bus.STATUS;
               if (bus.STATUS == ST_M) begin
                  wb_req_d = 1'b1;
                  state_d  = S_WB;
               end else begin
                  state_d  = S_RESP;
               end
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         S_WB: begin
            if (bus.WB_ACK) begin
               state_d  = S_RESP;
            end else begin
               wb_req_d = 1'b1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // MESI action for the one-cycle response
      if (state_d == S_RESP) begin
         done_d = 1'b1;
         if (stat_d != ST_I) begin
            if (cur_q.rw) begin
               pinv_d      = 1'b1;
               upd_valid_d = 1'b1;
               upd_state_d = ST_I;
            end else begin
               shared_d = 1'b1;
               if (stat_d != ST_S) begin
                  upd_valid_d = 1'b1;
                  upd_state_d = ST_S;
               end
            end
         end
         if (upd_valid_d) begin
            upd_index_d = cur_q.addr[7:0];
         end
      end
   end

   // FSM and output registers; reset drops a pending writeback at once
   always_ff @(posedge SCLK or negedge SRST) begin
      if (!SRST) begin
         state_q     <= S_IDLE;
         lat_q       <= '0;
         cur_q       <= '0;
         stat_q      <= ST_I;
         snoop_q     <= 1'b0;
         wb_req_q    <= 1'b0;
         done_q      <= 1'b0;
         shared_q    <= 1'b0;
         pinv_q      <= 1'b0;
         upd_valid_q <= 1'b0;
         upd_index_q <= 8'h00;
         upd_state_q <= ST_I;
      end else begin
         state_q     <= state_d;
         lat_q       <= lat_d;
         cur_q       <= cur_d;
         stat_q      <= stat_d;
         snoop_q     <= snoop_d;
         wb_req_q    <= wb_req_d;
         done_q      <= done_d;
         shared_q    <= shared_d;
         pinv_q      <= pinv_d;
         upd_valid_q <= upd_valid_d;
         upd_index_q <= upd_index_d;
         upd_state_q <= upd_state_d;
      end
   end

   assign bus.BUS_READY = ready_q;
   assign bus.snoop     = snoop_q;
   assign bus.ADDR      = cur_q.addr;
   assign bus.WB_REQ    = wb_req_q;
   assign bus.WB_ADDR   = cur_q.addr;
   assign bus.DONE      = done_q;
   assign bus.SHARED    = shared_q;
   assign bus.PINV      = pinv_q;
   assign bus.UPD_VALID = upd_valid_q;
   assign bus.UPD_INDEX = upd_index_q;
   assign bus.UPD_STATE = upd_state_q;

`ifdef SNOOP_STATS_EN
   logic [15:0] hit_cnt_q, hit_cnt_d;
   logic [15:0] inv_cnt_q, inv_cnt_d;

   // Saturating hit / invalidate counters, bumped during the response cycle
   always_comb begin
      hit_cnt_d = hit_cnt_q;
      inv_cnt_d = inv_cnt_q;
      if (state_q == S_RESP) begin
         if ((stat_q != ST_I) && (hit_cnt_q != 16'hFFFF)) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
         end
         if (pinv_q && (inv_cnt_q != 16'hFFFF)) begin
            inv_cnt_d = inv_cnt_q + 16'd1;
         end
      end
   end

   // Counter registers
   always_ff @(posedge SCLK or negedge SRST) begin
      if (!SRST) begin
         hit_cnt_q <= 16'h0000;
         inv_cnt_q <= 16'h0000;
      end else begin
         hit_cnt_q <= hit_cnt_d;
         inv_cnt_q <= inv_cnt_d;
      end
   end

   assign bus.HIT_CNT = hit_cnt_q;
   assign bus.INV_CNT = inv_cnt_q;
`endif
endmodule

// File: tb/tb_snoop_ctrl.sv
// tb_snoop_ctrl: vector table plus scoreboard for snoop_ctrl, with a
// directory/writeback responder and hand-written multi-cycle sequences.
module tb_snoop_ctrl;
   localparam int unsigned QDEPTH     = 4;
   localparam int unsigned LOOKUP_LAT = 1;

   logic SCLK = 1'b0;
   logic SRST;

   snoop_ctrl_if bus ();

   snoop_ctrl #(.QDEPTH(QDEPTH), .LOOKUP_LAT(LOOKUP_LAT)) dut (
      .SCLK (SCLK),
      .SRST (SRST),
      .bus  (bus)
   );

   always #5 SCLK = ~SCLK;

   typedef struct {
      logic [23:0] addr;
      logic        rw;
      logic [1:0]  status;
      int          wb_dly;
      logic        shared;
      logic        pinv;
      logic        upd_valid;
      logic [1:0]  upd_state;
   } vec_t;

   vec_t sb[$];
   vec_t vecs[9];
   vec_t fv[5];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   wb_cnt   = 0;

   function automatic vec_t mk(input logic [23:0] a, input logic rw, input logic [1:0] st,
                               input int dly, input logic sh, input logic pi,
                               input logic uv, input logic [1:0] us);
      vec_t v;
      v.addr = a; v.rw = rw; v.status = st; v.wb_dly = dly;
      v.shared = sh; v.pinv = pi; v.upd_valid = uv; v.upd_state = us;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s t=%0t", name, $time);
   endtask

   // Directory / writeback responder and scoreboard compare, once per negedge
   task automatic monitor();
      vec_t e;
      cyc++;
      if (bus.snoop === 1'b1) begin
         if (sb.size() == 0) fail("snoop_unexpected");
         else begin
            chk("snoop_addr", 32'(bus.ADDR), 32'(sb[0].addr));
            bus.STATUS = sb[0].status;
         end
         wb_cnt = 0;
      end
      if (bus.WB_REQ === 1'b1) begin
         wb_cnt++;
         if (sb.size() != 0) begin
            if (wb_cnt == 1) chk("wb_addr", 32'(bus.WB_ADDR), 32'(sb[0].addr));
            bus.WB_ACK = (wb_cnt >= sb[0].wb_dly);
         end
      end else begin
         bus.WB_ACK = 1'($urandom_range(0, 1));
      end
      if (bus.DONE === 1'b1) begin
         if (sb.size() == 0) fail("done_unexpected");
         else begin
            e = sb.pop_front();
            chk("shared", 32'(bus.SHARED), 32'(e.shared));
            chk("pinv", 32'(bus.PINV), 32'(e.pinv));
            chk("upd_valid", 32'(bus.UPD_VALID), 32'(e.upd_valid));
            if (e.upd_valid) begin
               chk("upd_index", 32'(bus.UPD_INDEX), 32'(e.addr[7:0]));
               chk("upd_state", 32'(bus.UPD_STATE), 32'(e.upd_state));
            end
            chk("wb_cycles", 32'(wb_cnt), 32'((e.status == 2'b11) ? e.wb_dly : 0));
         end
         bus.STATUS = 2'($urandom_range(0, 3));
         wb_cnt = 0;
      end else begin
         chk("quiet_outside_resp", 32'({bus.SHARED, bus.PINV, bus.UPD_VALID}), 32'(0));
      end
   endtask

   task automatic tick();
      @(posedge SCLK);
      @(negedge SCLK);
      monitor();
   endtask

   task automatic send(input vec_t v);
      int n;
      n = 0;
      while (bus.BUS_READY !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) fail("ready_timeout");
      else begin
         bus.BUS_VALID = 1'b1;
         bus.BUS_ADDR  = v.addr;
         bus.BUS_RW    = v.rw;
         sb.push_back(v);
         tick();
         bus.BUS_VALID = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 600) begin
         tick();
         n++;
      end
      if (sb.size() != 0) begin
         fail("drain_timeout");
         sb.delete();
      end
      tick();
      tick();
   endtask

   task automatic check_reset();
      chk("rst_bus_ready", 32'(bus.BUS_READY), 32'(1));
      chk("rst_snoop", 32'(bus.snoop), 32'(0));
      chk("rst_addr", 32'(bus.ADDR), 32'(0));
      chk("rst_upd_valid", 32'(bus.UPD_VALID), 32'(0));
      chk("rst_upd_index", 32'(bus.UPD_INDEX), 32'(0));
      chk("rst_upd_state", 32'(bus.UPD_STATE), 32'(0));
      chk("rst_pinv", 32'(bus.PINV), 32'(0));
      chk("rst_shared", 32'(bus.SHARED), 32'(0));
      chk("rst_wb_req", 32'(bus.WB_REQ), 32'(0));
      chk("rst_wb_addr", 32'(bus.WB_ADDR), 32'(0));
      chk("rst_done", 32'(bus.DONE), 32'(0));
   endtask

   initial begin
      int   dc[$];
      logic got;
      int   n;

      SRST          = 1'b0;
      bus.BUS_VALID = 1'b0;
      bus.BUS_ADDR  = '0;
      bus.BUS_RW    = 1'b0;
      bus.STATUS    = 2'b00;
      bus.WB_ACK    = 1'b0;

      //             addr        rw    st     dly sh    pi    uv    us
      vecs[0] = mk(24'h123445, 1'b0, 2'b10, 0, 1'b1, 1'b0, 1'b1, 2'b01);
      vecs[1] = mk(24'hABCD01, 1'b1, 2'b11, 3, 1'b0, 1'b1, 1'b1, 2'b00);
      vecs[2] = mk(24'h000010, 1'b0, 2'b00, 0, 1'b0, 1'b0, 1'b0, 2'b00);
      vecs[3] = mk(24'h000011, 1'b1, 2'b00, 0, 1'b0, 1'b0, 1'b0, 2'b00);
      vecs[4] = mk(24'h5A5A22, 1'b0, 2'b01, 0, 1'b1, 1'b0, 1'b0, 2'b00);
      vecs[5] = mk(24'h5A5A33, 1'b1, 2'b01, 0, 1'b0, 1'b1, 1'b1, 2'b00);
      vecs[6] = mk(24'h0F0F44, 1'b1, 2'b10, 0, 1'b0, 1'b1, 1'b1, 2'b00);
      vecs[7] = mk(24'h777755, 1'b0, 2'b11, 1, 1'b1, 1'b0, 1'b1, 2'b01);
      vecs[8] = mk(24'hFFFFFF, 1'b1, 2'b11, 2, 1'b0, 1'b1, 1'b1, 2'b00);

      fv[0] = mk(24'h110010, 1'b0, 2'b01, 0, 1'b1, 1'b0, 1'b0, 2'b00);
      fv[1] = mk(24'h220020, 1'b1, 2'b10, 0, 1'b0, 1'b1, 1'b1, 2'b00);
      fv[2] = mk(24'h330030, 1'b0, 2'b00, 0, 1'b0, 1'b0, 1'b0, 2'b00);
      fv[3] = mk(24'h440040, 1'b1, 2'b11, 2, 1'b0, 1'b1, 1'b1, 2'b00);
      fv[4] = mk(24'h550050, 1'b0, 2'b10, 0, 1'b1, 1'b0, 1'b1, 2'b01);

      @(negedge SCLK);
      @(negedge SCLK);
      check_reset();
      SRST = 1'b1;
      tick();
      tick();

      // Latency: accept at edge k, snoop in cycle k+1, DONE in cycle k+3
      bus.BUS_VALID = 1'b1;
      bus.BUS_ADDR  = vecs[0].addr;
      bus.BUS_RW    = vecs[0].rw;
      sb.push_back(vecs[0]);
      tick();
      bus.BUS_VALID = 1'b0;
      chk("lat_snoop_k", 32'(bus.snoop), 32'(0));
      tick();
      chk("lat_snoop_k1", 32'(bus.snoop), 32'(1));
      chk("lat_addr_k1", 32'(bus.ADDR), 32'(24'h123445));
      tick();
      chk("lat_done_k2", 32'(bus.DONE), 32'(0));
      tick();
      chk("lat_done_k3", 32'(bus.DONE), 32'(1));
      chk("lat_shared_k3", 32'(bus.SHARED), 32'(1));
      chk("lat_upd_index_k3", 32'(bus.UPD_INDEX), 32'(8'h45));
      chk("lat_upd_state_k3", 32'(bus.UPD_STATE), 32'(2'b01));
      drain();

      // Table, one transaction at a time
      for (int i = 0; i < 9; i++) begin
         send(vecs[i]);
         drain();
      end

      // Table, back-to-back through the queue
      for (int i = 0; i < 9; i++) send(vecs[i]);
      drain();

      // Throughput: non-M snoops complete every 3 + LOOKUP_LAT cycles
      send(vecs[2]);
      send(vecs[4]);
      send(vecs[6]);
      for (int k = 0; k < 60 && dc.size() < 3; k++) begin
         tick();
         if (bus.DONE === 1'b1) dc.push_back(cyc);
      end
      if (dc.size() != 3) fail("throughput_timeout");
      else begin
         chk("throughput_gap1", 32'(dc[1] - dc[0]), 32'(3 + LOOKUP_LAT));
         chk("throughput_gap2", 32'(dc[2] - dc[1]), 32'(3 + LOOKUP_LAT));
      end
      drain();

      // Queue full while the FSM is stalled in a long writeback
      send(mk(24'h100001, 1'b0, 2'b11, 12, 1'b1, 1'b0, 1'b1, 2'b01));
      for (int i = 0; i < 4; i++) send(fv[i]);
      chk("full_ready_low", 32'(bus.BUS_READY), 32'(0));
      bus.BUS_VALID = 1'b1;
      bus.BUS_ADDR  = fv[4].addr;
      bus.BUS_RW    = fv[4].rw;
      sb.push_back(fv[4]);
      got = 1'b0;
      n   = 0;
      while (!got && n < 40) begin
         tick();
         n++;
         if (bus.snoop === 1'b1) got = 1'b1;
         else chk("full_ready_hold", 32'(bus.BUS_READY), 32'(0));
      end
      bus.BUS_VALID = 1'b0;
      if (!got) fail("full_pop_timeout");
      else chk("full_pushpop_ready", 32'(bus.BUS_READY), 32'(0));
      drain();

      // Reset in the middle of a writeback with a queued request behind it
      send(mk(24'h200002, 1'b1, 2'b11, 40, 1'b0, 1'b1, 1'b1, 2'b00));
      send(vecs[0]);
      n = 0;
      while (bus.WB_REQ !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (bus.WB_REQ !== 1'b1) fail("wb_req_timeout");
      #2;
      SRST = 1'b0;
      #1;
      check_reset();
      sb.delete();
      wb_cnt     = 0;
      bus.WB_ACK = 1'b0;
      bus.STATUS = 2'b00;
`ifdef SNOOP_STATS_EN
      chk("rst_hit_cnt", 32'(bus.HIT_CNT), 32'(0));
      chk("rst_inv_cnt", 32'(bus.INV_CNT), 32'(0));
`endif
      @(negedge SCLK);
      SRST = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("post_rst_snoop", 32'(bus.snoop), 32'(0));
         chk("post_rst_done", 32'(bus.DONE), 32'(0));
         chk("post_rst_ready", 32'(bus.BUS_READY), 32'(1));
      end

`ifdef SNOOP_STATS_EN
      // Three hits (one write) and one miss
      send(vecs[0]);
      send(vecs[5]);
      send(vecs[7]);
      send(vecs[2]);
      drain();
      chk("hit_cnt", 32'(bus.HIT_CNT), 32'(3));
      chk("inv_cnt", 32'(bus.INV_CNT), 32'(1));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
